// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU.
package alu_pkg;

    // Single-cycle opcodes
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_SLTU  = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;

    // Iterative opcodes; the low two bits select the muldiv operation
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_REMU  = 4'b1011;

    // Handshake FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_iterative(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per cycle.
// op: 00 MUL low, 01 MULHU high, 10 DIVU quotient, 11 REMU remainder.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res
);

    localparam int CW = $clog2(W + 1);

    // hi holds the product high half / partial remainder,
    // lo holds the multiplier-then-product low half / dividend-then-quotient.
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  b_q, b_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W:0]    sum;
    logic [W:0]    shifted;
    logic          ge;
    logic [W-1:0]  diff;
    logic [W-1:0]  hi_step;
    logic [W-1:0]  lo_step;

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CW'(1));
    // The final step's value is exposed so the top can capture it on the same edge
    assign res  = op_q[0] ? hi_step : lo_step;

    // One iteration step and operand load on start
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        op_d  = op_q;
        cnt_d = cnt_q;

        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[W-1]};
        ge      = (shifted >= {1'b0, b_q});
        // When ge holds the true difference fits in W bits; with b == 0 the
        // low W bits are exactly the shifted remainder, yielding REMU = a.
        diff    = shifted[W-1:0] - b_q;

        if (op_q[1]) begin
            hi_step = ge ? diff : shifted[W-1:0];
            lo_step = {lo_q[W-2:0], ge};
        end else begin
            hi_step = sum[W:1];
            lo_step = {sum[0], lo_q[W-1:1]};
        end

        if (start) begin
            hi_d  = '0;
            lo_d  = a;
            b_d   = b;
            op_d  = op;
            cnt_d = CW'(W);
        end else if (busy) begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops plus iterative MUL/MULHU/DIVU/REMU behind valid/ready.
module seq_alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   AluOpcode,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Result,
    output logic         ZeroFlag,
    output logic         NegFlag,
    output logic         IllegalOp
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] result_q, result_d;
    logic         zero_q, zero_d;
    logic         neg_q, neg_d;
    logic         illegal_q, illegal_d;

    logic         accept;
    logic         iter_op;
    logic         iter_start;
    logic         iter_busy;
    logic         iter_done;
    logic [W-1:0] iter_res;
    logic [W-1:0] alu_res;
    logic         alu_illegal;
    logic         load;
    logic [W-1:0] load_val;
    logic         load_ill;

    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign iter_op    = is_iterative(AluOpcode);
    assign iter_start = accept && iter_op;

    assign out_valid  = (state_q == ST_DONE);
    assign Result     = result_q;
    assign ZeroFlag   = zero_q;
    assign NegFlag    = neg_q;
    assign IllegalOp  = illegal_q;

    iter_muldiv #(.W(W)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (iter_start),
        .op    (AluOpcode[1:0]),
        .a     (InputA),
        .b     (InputB),
        .busy  (iter_busy),
        .done  (iter_done),
        .res   (iter_res)
    );

    // Single-cycle datapath on the incoming operands
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (AluOpcode)
            OP_ADD:  alu_res = InputA + InputB;
            OP_SUB:  alu_res = InputA - InputB;
            OP_AND:  alu_res = InputA & InputB;
            OP_OR:   alu_res = InputA | InputB;
            OP_SLTU: alu_res = W'(InputA < InputB);
            OP_SLT:  alu_res = W'($signed(InputA) < $signed(InputB));
            OP_XOR:  alu_res = InputA ^ InputB;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Handshake FSM; result and flags change only on entry to DONE
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = alu_res;
        load_ill = alu_illegal;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = iter_op ? ST_CALC : ST_DONE;
                    load    = !iter_op;
                end
            end
            ST_CALC: begin
                if (iter_done) begin
                    state_d  = ST_DONE;
                    load     = 1'b1;
                    load_val = iter_res;
                    load_ill = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = iter_op ? ST_CALC : ST_DONE;
                        load    = !iter_op;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        result_d  = load ? load_val : result_q;
        zero_d    = load ? (load_val == '0) : zero_q;
        neg_d     = load ? load_val[W-1] : neg_q;
        illegal_d = load ? load_ill : illegal_q;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            illegal_q <= illegal_d;
        end
    end

    // The iteration counter must be running whenever the FSM sits in CALC
    calc_implies_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_CALC) |-> iter_busy);

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the single-cycle core ALU. It keeps the single-cycle ADD/SUB/logic/compare operations and adds iterative unsigned multiply and divide, using a valid/ready handshake on both sides. It sits between the datapath operand registers and the write-back mux, and lets the multi-cycle core issue M-extension style operations without stretching the clock.

## Interface
- W, 32: operand and result width; must be ≥ 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- AluOpcode  in  4  operation select; encodings are under Operation.
- InputA  in  W  operand A; a signed operand for SUB and SLT only.
- InputB  in  W  operand B.
- out_valid  out  1  Result and flags are valid and held.
- out_ready  in  1  consumer takes the result.
- Result  out  W  registered result.
- ZeroFlag  out  1  registered; asserted when Result == 0.
- NegFlag  out  1  registered; equals Result[W-1].
- IllegalOp  out  1  registered; the accepted opcode was unassigned.

## Operation
- Reset is asynchronous and active-low. Effects:
  - state = IDLE.
  - out_valid, Result, ZeroFlag, NegFlag and IllegalOp are all 0.
  - The iteration counter is 0.
- Opcodes, single-cycle:
  - 0000 ADD.
  - 0001 SUB.
  - 0010 AND.
  - 0011 OR.
  - 0100 SLTU.
  - 0101 SLT (signed).
  - 0110 XOR.
- Opcodes, iterative:
  - 1000 MUL: low W bits of the product.
  - 1001 MULHU: high W bits of the unsigned product.
  - 1010 DIVU: unsigned quotient.
  - 1011 REMU: unsigned remainder.
- Unassigned opcodes are single-cycle: Result = 0, IllegalOp = 1.
- ADD, SUB and MUL wrap modulo 2^W. SLT and SLTU return 0 or 1, zero-extended.
- Divide by zero: DIVU returns all ones; REMU returns InputA. No trap is raised.
- Handshake:
  - A request is accepted when in_valid && in_ready.
  - Operands and opcode are captured on acceptance. The caller may change them afterwards.
- in_ready = (state == IDLE) || (state == DONE && out_ready). It is combinational.
- State machine:
  - IDLE → DONE on accept of a single-cycle opcode.
  - IDLE → CALC on accept of an iterative opcode. The counter loads W.
  - CALC: one shift-add or restoring-subtract step per cycle, counter decrements. When counter == 1, the step completes → DONE.
  - DONE: out_valid = 1 and outputs are held stable. On out_ready:
    - with a simultaneous accept, re-enter DONE (single-cycle opcode) or CALC (iterative);
    - without one, go to IDLE.
- Result and all flags update only when entering DONE. They keep their value in IDLE.
- Reset asserted in CALC or DONE aborts the operation. No out_valid is produced for it.

## Timing
- Single-cycle op accepted at edge t: out_valid from cycle t+1.
- Iterative op accepted at edge t: out_valid from cycle t+W+1. With W=32, that is 33 cycles after accept.
- Back-to-back single-cycle ops with out_ready held at 1 sustain one result per cycle.
- out_ready low in DONE stalls indefinitely. Result is held and in_ready = 0.
- No combinational path from InputA, InputB or AluOpcode to any output. in_ready depends only on state and out_ready.

## Structure
- Package alu_pkg:
  - 4-bit opcode localparams (ADD … REMU).
  - state encoding IDLE/CALC/DONE.
  - helper is_iterative(opcode).
- Sub-module iter_muldiv, parametrised by W:
  - owns the counter and the accumulator/remainder and quotient registers;
  - interface start, op[1:0], a, b → busy, done, res.
  - The top-level block holds the handshake FSM and the single-cycle datapath.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 1, out_ready held at 1 → out_valid at t+1, Result = 0x80000000, NegFlag = 1, ZeroFlag = 0.
- SLT(-1, 1) = 1 and SLTU(0xFFFFFFFF, 1) = 0, issued back-to-back → one result per cycle, in_ready held at 1.
- MUL and MULHU of 0xFFFFFFFF × 0xFFFFFFFF → Result 0x00000001 and 0xFFFFFFFE, each at t+33, in_ready = 0 during CALC.
- DIVU and REMU of 100 by 7 → 14 and 2. DIVU and REMU of 5 by 0 → 0xFFFFFFFF and 5.
- DIVU completes with out_ready = 0 for 5 cycles → Result stable, no new accept. Then out_ready = 1 with in_valid ADD 0 + 0 → ADD accepted the same cycle, next Result = 0, ZeroFlag = 1.
- rst_n pulsed low mid-CALC (cycle 10 of a MUL); opcode 1111 issued after reset → MUL aborted, all outputs 0, IDLE; opcode 1111 then gives IllegalOp = 1, Result = 0.
